// File: rtl/axis_multichannel_delay_pkg.sv
// axis_multichannel_delay_pkg: shared delay clamp and range-check helpers
package axis_multichannel_delay_pkg;
  function automatic int unsigned clamp_delay(input int unsigned v, input int unsigned max_lat);
    return (v == 0) ? 1 : (v > max_lat) ? max_lat : v;
  endfunction
  function automatic logic delay_out_of_range(input int unsigned v, input int unsigned max_lat);
    return (v == 0) || (v > max_lat);
  endfunction
endpackage

// File: rtl/axis_multichannel_delay_lane.sv
// axis_delay_lane: one circular-buffer delay lane with clamp, flush and error flag
module axis_delay_lane
  import axis_multichannel_delay_pkg::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int MAX_LATENCY = 64,
  parameter int DELAY_WIDTH = 16,
  parameter int RESET_DELAY = 1,
  parameter int PTR_WIDTH   = $clog2(MAX_LATENCY)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PTR_WIDTH-1:0]   wr_ptr,
  input  logic [DELAY_WIDTH-1:0] delay_count,
  input  logic                   delay_load,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  output logic                   flushing,
  output logic                   delay_err
);
  localparam int DCW = PTR_WIDTH + 1;
  logic [DATA_WIDTH:0] ram [MAX_LATENCY];
  logic [MAX_LATENCY-1:0] vld_q, vld_d;
  logic [DCW-1:0] d_q, d_d, cnt_q, cnt_d, d_new;
  logic err_q, err_d, chg, byp;
  logic [PTR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d;
  always_comb begin
    d_new = DCW'(clamp_delay(32'(delay_count), MAX_LATENCY));
    chg = delay_load && (d_new != d_q);
    d_d = delay_load ? d_new : d_q;
    err_d = err_q | (delay_load & delay_out_of_range(32'(delay_count), MAX_LATENCY));
    cnt_d = chg ? d_new : (cnt_q != '0) ? cnt_q - DCW'(1) : cnt_q;
    vld_d = chg ? '0 : vld_q;
    vld_d[wr_ptr] = s_tvalid;
    rd = wr_ptr - PTR_WIDTH'(d_q - DCW'(1));
    // D=1 reads the slot being written this edge, so forward the input
    byp = (d_d == DCW'(1));
    valid_d = byp ? s_tvalid : (!chg && vld_q[rd]);
    last_d = valid_d & (byp ? s_tlast : ram[rd][DATA_WIDTH]);
    data_d = byp ? s_tdata : ram[rd][DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk) ram[wr_ptr] <= {s_tvalid & s_tlast, s_tdata};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= '0;
      d_q <= DCW'(RESET_DELAY);
      cnt_q <= '0;
      err_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
    end
  assign m_tdata = data_q;
  assign m_tvalid = valid_q;
  assign m_tlast = last_q;
  assign flushing = (cnt_q != '0);
  assign delay_err = err_q;
endmodule

// File: rtl/axis_multichannel_delay.sv
// axis_multichannel_delay: per-lane programmable fixed-latency AXI-Stream delay with shared write pointer
module axis_multichannel_delay
  import axis_multichannel_delay_pkg::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int NUM_CH      = 4,
  parameter int MAX_LATENCY = 64,
  parameter int DELAY_WIDTH = 16,
  parameter int RESET_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*DELAY_WIDTH-1:0] delay_count,
  input  logic [NUM_CH-1:0]             delay_load,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_CH-1:0]             s_axis_tvalid,
  input  logic [NUM_CH-1:0]             s_axis_tlast,
  output logic [NUM_CH*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [NUM_CH-1:0]             m_axis_tvalid,
  output logic [NUM_CH-1:0]             m_axis_tlast,
  output logic [NUM_CH-1:0]             flushing,
  output logic [NUM_CH-1:0]             delay_err
);
  localparam int PTR_WIDTH = $clog2(MAX_LATENCY);
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  always_comb wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) wr_ptr_q <= '0;
    else wr_ptr_q <= wr_ptr_d;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    axis_delay_lane #(
      .DATA_WIDTH(DATA_WIDTH), .MAX_LATENCY(MAX_LATENCY),
      .DELAY_WIDTH(DELAY_WIDTH), .RESET_DELAY(RESET_DELAY), .PTR_WIDTH(PTR_WIDTH)
    ) u_lane (
      .clk(clk), .rst(rst), .wr_ptr(wr_ptr_q),
      .delay_count(delay_count[k*DELAY_WIDTH +: DELAY_WIDTH]),
      .delay_load(delay_load[k]),
      .s_tdata(s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]),
      .s_tvalid(s_axis_tvalid[k]),
      .s_tlast(s_axis_tlast[k]),
      .m_tdata(m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]),
      .m_tvalid(m_axis_tvalid[k]),
      .m_tlast(m_axis_tlast[k]),
      .flushing(flushing[k]),
      .delay_err(delay_err[k])
    );
  end
endmodule

// File: tb/tb_axis_multichannel_delay.sv
// tb_axis_multichannel_delay: randomized self-checking bench against a timestamped history model
module tb_axis_multichannel_delay;
  localparam int DW = 256, NC = 4, ML = 64, DLW = 16, RD = 1;
  logic clk = 0, rst = 1;
  logic [NC*DLW-1:0] delay_count = '0;
  logic [NC-1:0] delay_load = '0, s_tvalid = '0, s_tlast = '0;
  logic [NC*DW-1:0] s_tdata = '0, m_tdata;
  logic [NC-1:0] m_tvalid, m_tlast, flushing, delay_err;
  int errors = 0, checks = 0, n = 0;
  logic [DW-1:0] hd [NC][256];
  bit hv [NC][256], hl [NC][256];
  int md [NC], epoch [NC], fl_end [NC];
  bit merr [NC];

  axis_multichannel_delay #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_LATENCY(ML), .DELAY_WIDTH(DLW), .RESET_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .delay_count(delay_count), .delay_load(delay_load),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .flushing(flushing), .delay_err(delay_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic beat(input int k, input logic [DW-1:0] d, input bit l);
    s_tdata[k*DW +: DW] = d;
    s_tvalid[k] = 1'b1;
    s_tlast[k] = l;
  endtask

  task automatic load(input int k, input int v);
    delay_count[k*DLW +: DLW] = DLW'(v);
    delay_load[k] = 1'b1;
  endtask

  // Output after edge e carries the beat sampled at edge e-D+1, provided it
  // entered after the lane's last reset or delay change.
  task automatic tick();
    @(posedge clk);
    n++;
    for (int k = 0; k < NC; k++) begin
      if (rst) begin
        md[k] = RD; epoch[k] = n + 1; fl_end[k] = 0; merr[k] = 0;
      end else begin
        if (delay_load[k]) begin
          int v, dn;
          v = int'(delay_count[k*DLW +: DLW]);
          dn = (v == 0) ? 1 : (v > ML) ? ML : v;
          if (v == 0 || v > ML) merr[k] = 1;
          if (dn != md[k]) begin md[k] = dn; epoch[k] = n; fl_end[k] = n + dn; end
        end
        hv[k][n % 256] = s_tvalid[k];
        hl[k][n % 256] = s_tlast[k];
        hd[k][n % 256] = s_tdata[k*DW +: DW];
      end
    end
    #1;
    for (int k = 0; k < NC; k++) begin
      int t;
      bit ev, el;
      t = n - md[k] + 1;
      ev = 0; el = 0;
      if (!rst && t >= epoch[k]) begin ev = hv[k][t % 256]; el = ev & hl[k][t % 256]; end
      check($sformatf("tvalid%0d", k), DW'(m_tvalid[k]), DW'(ev));
      check($sformatf("tlast%0d", k), DW'(m_tlast[k]), DW'(el));
      if (ev) check($sformatf("tdata%0d", k), m_tdata[k*DW +: DW], hd[k][t % 256]);
      check($sformatf("flushing%0d", k), DW'(flushing[k]), DW'(!rst && n < fl_end[k]));
      check($sformatf("delay_err%0d", k), DW'(delay_err[k]), DW'(merr[k]));
    end
    delay_load = '0;
    s_tvalid = '0;
    s_tlast = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_tvalid", DW'(m_tvalid), '0);
    check("rst_tlast", DW'(m_tlast), '0);
    check("rst_tdata", m_tdata[DW-1:0], '0);
    check("rst_flush", DW'(flushing), '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 4; i++) begin beat(0, DW'(8'hA1 + i), i == 3); tick(); end
    repeat (3) tick();
    load(1, 10); tick();
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) beat(1, DW'(8'h55), 0);
      if (i == 20) load(1, 10);
      tick();
    end
    repeat (10) tick();
    load(2, 5); tick();
    for (int i = 0; i < 15; i++) begin beat(2, rnd(), $urandom_range(0, 1)); tick(); end
    load(2, 20); beat(2, rnd(), 0); tick();
    for (int i = 0; i < 30; i++) begin beat(2, rnd(), $urandom_range(0, 1)); tick(); end
    load(3, 0); tick();
    repeat (3) tick();
    load(3, 200); beat(3, rnd(), 1); tick();
    for (int i = 0; i < 70; i++) begin beat(3, rnd(), $urandom_range(0, 1)); tick(); end
    load(0, ML); tick();
    for (int i = 0; i < 3 * ML; i++) begin beat(0, rnd(), $urandom_range(0, 1)); tick(); end
    repeat (ML + 4) tick();
    load(0, 7); load(1, 1); tick();
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < NC; k++) beat(k, rnd(), $urandom_range(0, 1));
      tick();
    end
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NC; k++) begin
        if ($urandom_range(0, 9) < 6) beat(k, rnd(), $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 49) == 0) load(k, ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, 80)));
      end
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
